// File: rtl/board_mem_display.sv
// Board-side viewer for the CPU data-memory debug port: picks a word address (switches or
// auto-scan), captures the returned word and shows it as 8 hex digits on a muxed 7-seg display.
module board_mem_display #(
  parameter int REFRESH_DIV = 100000,
  parameter int AUTO_DIV    = 100000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  sw_addr,
  input  logic        auto_mode,
  input  logic        btn_next,
  input  logic [31:0] mem_read_result,
  output logic [5:0]  mem_read_addr,
  output logic [5:0]  addr_led,
  output logic        data_valid,
  output logic [7:0]  an,
  output logic [7:0]  seg
);

  localparam int REF_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int AUTO_W = (AUTO_DIV > 1) ? $clog2(AUTO_DIV) : 1;
  localparam logic [REF_W-1:0]  REF_LAST  = REF_W'(REFRESH_DIV - 1);
  localparam logic [AUTO_W-1:0] AUTO_LAST = AUTO_W'(AUTO_DIV - 1);

  typedef enum logic {SETTLE, TRACK} cap_state_t;

  logic [5:0]        sw_s1, sw_s2;
  logic              mode_s1, mode_s2;
  logic              btn_s1, btn_s2, btn_d;
  logic              btn_pulse;
  logic [5:0]        addr, addr_next;
  logic              addr_chg;
  logic [AUTO_W-1:0] auto_cnt, auto_cnt_next;
  cap_state_t        state, state_next;
  logic [1:0]        settle_cnt, settle_cnt_next;
  logic              load_data;
  logic [31:0]       shown_data;
  logic [2:0]        digit;
  logic [REF_W-1:0]  ref_cnt;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sw_s1   <= '0;
      sw_s2   <= '0;
      mode_s1 <= 1'b0;
      mode_s2 <= 1'b0;
      btn_s1  <= 1'b0;
      btn_s2  <= 1'b0;
      btn_d   <= 1'b0;
    end else begin
      sw_s1   <= sw_addr;
      sw_s2   <= sw_s1;
      mode_s1 <= auto_mode;
      mode_s2 <= mode_s1;
      btn_s1  <= btn_next;
      btn_s2  <= btn_s1;
      btn_d   <= btn_s2;
    end
  end

  assign btn_pulse = btn_s2 & ~btn_d;

  // Manual mode holds auto_cnt at zero, so entering auto mode always starts a fresh period.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    addr_next     = addr;
    auto_cnt_next = '0;
    if (mode_s2) begin
      if (btn_pulse || auto_cnt == AUTO_LAST) begin
        addr_next = addr + 6'd1;
      end else begin
        auto_cnt_next = auto_cnt + AUTO_W'(1);
      end
    end else begin
      addr_next = sw_s2;
    end
  end

  assign addr_chg = (addr_next != addr);

  // Two settle cycles after an address change, then track the port continuously.
  always_comb begin
    state_next      = state;
    settle_cnt_next = settle_cnt;
    load_data       = 1'b0;
    if (addr_chg) begin
      state_next      = SETTLE;
      settle_cnt_next = 2'd0;
    end else begin
      case (state)
        SETTLE: begin
          if (settle_cnt == 2'd2) begin
            state_next = TRACK;
            load_data  = 1'b1;
          end else begin
            settle_cnt_next = settle_cnt + 2'd1;
          end
        end
        TRACK:   load_data = 1'b1;
        default: state_next = SETTLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr       <= '0;
      auto_cnt   <= '0;
      state      <= SETTLE;
      settle_cnt <= '0;
      shown_data <= '0;
    end else begin
      addr       <= addr_next;
      auto_cnt   <= auto_cnt_next;
      state      <= state_next;
      settle_cnt <= settle_cnt_next;
      if (load_data) shown_data <= mem_read_result;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ref_cnt <= '0;
      digit   <= '0;
    end else if (ref_cnt == REF_LAST) begin
      ref_cnt <= '0;
      digit   <= digit + 3'd1;
    end else begin
      ref_cnt <= ref_cnt + REF_W'(1);
    end
  end

  function automatic logic [6:0] hex7(input logic [3:0] nib);
    case (nib)
      4'h0: hex7 = 7'b1000000;
      4'h1: hex7 = 7'b1111001;
      4'h2: hex7 = 7'b0100100;
      4'h3: hex7 = 7'b0110000;
      4'h4: hex7 = 7'b0011001;
      4'h5: hex7 = 7'b0010010;
      4'h6: hex7 = 7'b0000010;
      4'h7: hex7 = 7'b1111000;
      4'h8: hex7 = 7'b0000000;
      4'h9: hex7 = 7'b0010000;
      4'hA: hex7 = 7'b0001000;
      4'hB: hex7 = 7'b0000011;
      4'hC: hex7 = 7'b1000110;
      4'hD: hex7 = 7'b0100001;
      4'hE: hex7 = 7'b0000110;
      default: hex7 = 7'b0001110;
    endcase
  endfunction

  assign an            = ~(8'b1 << digit);
  assign seg           = {1'b1, hex7(shown_data[4*digit +: 4])};
  assign data_valid    = (state == TRACK);
  assign mem_read_addr = addr;
  assign addr_led      = addr;

endmodule

// File: tb/tb_board_mem_display.sv
// Directed bench for board_mem_display with a small combinational memory model on the read port.
module tb_board_mem_display;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  sw_addr;
  logic        auto_mode;
  logic        btn_next;
  logic [31:0] mem_read_result;
  logic [5:0]  mem_read_addr;
  logic [5:0]  addr_led;
  logic        data_valid;
  logic [7:0]  an;
  logic [7:0]  seg;

  logic [31:0] mem [64];
  int n_cmp = 0;
  int n_err = 0;

  board_mem_display #(.REFRESH_DIV(4), .AUTO_DIV(16)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .sw_addr         (sw_addr),
    .auto_mode       (auto_mode),
    .btn_next        (btn_next),
    .mem_read_result (mem_read_result),
    .mem_read_addr   (mem_read_addr),
    .addr_led        (addr_led),
    .data_valid      (data_valid),
    .an              (an),
    .seg             (seg)
  );

  always #5 clk = ~clk;

  assign mem_read_result = mem[mem_read_addr];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_digit(input int d);
    logic [7:0] want;
    want = ~(8'b1 << d);
    for (int i = 0; i < 40 && an !== want; i++) step(1);
    check($sformatf("an_digit%0d", d), {24'd0, an}, {24'd0, want});
  endtask

  task automatic check_addr(input string tag, input logic [5:0] exp);
    check(tag, {26'd0, mem_read_addr}, {26'd0, exp});
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[5]  = 32'h1234ABCD;
    mem[9]  = 32'hCAFE0009;
    mem[40] = 32'h89ABCDEF;
    rst_n = 1'b0; sw_addr = 6'd0; auto_mode = 1'b0; btn_next = 1'b0;

    // Reset and digit scan
    step(2);
    check_addr("rst_addr", 6'd0);
    check("rst_an", {24'd0, an}, 32'hFE);
    check("rst_seg", {24'd0, seg}, 32'hC0);
    check("rst_valid", {31'd0, data_valid}, 32'd0);
    rst_n = 1'b1;
    for (int k = 0; k < 9; k++) begin
      logic [7:0] want;
      want = ~(8'b1 << (k % 8));
      check($sformatf("scan%0d_first", k), {24'd0, an}, {24'd0, want});
      check($sformatf("scan%0d_seg", k), {24'd0, seg}, 32'hC0);
      step(3);
      check($sformatf("scan%0d_last", k), {24'd0, an}, {24'd0, want});
      step(1);
    end
    check("idle_valid", {31'd0, data_valid}, 32'd1);

    // Manual read of address 5
    sw_addr = 6'd5;
    step(2); check_addr("man_addr_e2", 6'd0);
    step(1); check_addr("man_addr_e3", 6'd5);
    check("man_led", {26'd0, addr_led}, 32'd5);
    check("man_valid_n", {31'd0, data_valid}, 32'd0);
    step(2); check("man_valid_n2", {31'd0, data_valid}, 32'd0);
    step(1); check("man_valid_n3", {31'd0, data_valid}, 32'd1);
    wait_digit(0); check("seg_d0", {24'd0, seg}, 32'hA1);
    wait_digit(1); check("seg_d1", {24'd0, seg}, 32'hC6);
    wait_digit(3); check("seg_d3", {24'd0, seg}, 32'h88);
    wait_digit(7); check("seg_d7", {24'd0, seg}, 32'hF9);

    // Live update while tracking, then a new address
    mem[5] = 32'h0;
    step(1);
    check("live_seg", {24'd0, seg}, 32'hC0);
    check("live_valid", {31'd0, data_valid}, 32'd1);
    sw_addr = 6'd9;
    step(2); check("chg_valid_pre", {31'd0, data_valid}, 32'd1);
    check_addr("chg_addr_pre", 6'd5);
    step(1); check_addr("chg_addr", 6'd9);
    check("chg_valid0", {31'd0, data_valid}, 32'd0);
    step(2); check("chg_valid2", {31'd0, data_valid}, 32'd0);
    step(1); check("chg_valid3", {31'd0, data_valid}, 32'd1);

    // Auto scan wrap from 62
    sw_addr = 6'd62;
    step(6); check_addr("auto_start", 6'd62);
    auto_mode = 1'b1;
    step(17); check_addr("auto_62_hold", 6'd62);
    step(1);  check_addr("auto_63", 6'd63);
    step(15); check_addr("auto_63_hold", 6'd63);
    step(1);  check_addr("auto_wrap0", 6'd0);

    // Held button: one step, then auto period restarts from the pulse
    btn_next = 1'b1;
    step(2); check_addr("btn_e2", 6'd0);
    step(1); check_addr("btn_e3", 6'd1);
    step(7); btn_next = 1'b0;
    check_addr("btn_held", 6'd1);
    step(8); check_addr("btn_period_hold", 6'd1);
    step(1); check_addr("btn_period_step", 6'd2);

    // Button pulse coincident with terminal count
    step(13); btn_next = 1'b1;
    step(2); check_addr("coin_pre", 6'd2);
    step(1); check_addr("coin_once", 6'd3);
    step(3); btn_next = 1'b0;
    step(12); check_addr("coin_hold", 6'd3);
    step(1);  check_addr("coin_next", 6'd4);

    // Mid-operation reset while tracking address 40
    auto_mode = 1'b0; sw_addr = 6'd40;
    step(10); check_addr("mid_addr40", 6'd40);
    check("mid_valid", {31'd0, data_valid}, 32'd1);
    rst_n = 1'b0;
    step(1);
    check_addr("mid_rst_addr", 6'd0);
    check("mid_rst_led", {26'd0, addr_led}, 32'd0);
    check("mid_rst_an", {24'd0, an}, 32'hFE);
    check("mid_rst_seg", {24'd0, seg}, 32'hC0);
    check("mid_rst_valid", {31'd0, data_valid}, 32'd0);

    // Auto -> manual with a simultaneous button press
    auto_mode = 1'b1; sw_addr = 6'd9; rst_n = 1'b1;
    step(5); check_addr("a2m_auto_hold", 6'd0);
    auto_mode = 1'b0; btn_next = 1'b1;
    step(2); check_addr("a2m_e2", 6'd0);
    step(1); check_addr("a2m_e3", 6'd9);
    step(3); check_addr("a2m_btn_ignored", 6'd9);
    btn_next = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
